fixed_to_float: RTL and testbench
=================================

Name: fixed_to_float

Overview:
- Multicycle Nios II custom-instruction block that converts the cosine unit's unsigned fixed-point output back to IEEE-754 single precision.
- The cosine unit takes float32 in and returns unsigned fixed point with 31 fractional bits; this block performs the reverse conversion on that output.
- Sits after the cosine unit in the custom-instruction datapath, so software receives a float result.
- Iterative normaliser (one shift per cycle) followed by a round-to-nearest-even stage.

Parameters:
- FRAC_BITS, 31, number of fractional bits in dataa (legal range 0..31); value = dataa / 2^FRAC_BITS.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous and active-high
- clk_en  input  1  clock enable; when low, all registers hold
- start  input  1  one-cycle request; dataa is sampled on the same edge
- dataa  input  32  unsigned fixed-point operand
- done  output  1  one-cycle pulse; result is valid in the same cycle
- result  output  32  float32 result; holds its value until the next completion

Behaviour:
- Reset values: done=0, result=32'h0, state IDLE. Reset asserted mid-operation aborts the conversion; no done pulse is produced.
- clk_en=0 freezes state, the shift register, the exponent and done. A done pulse that is pending stays asserted until the next enabled edge.
- States: IDLE, NORM, ROUND.
- IDLE, start=1, dataa==0: result<=0, done<=1 on the same edge; state stays IDLE. Latency 1.
- IDLE, start=1, dataa!=0: mant<=dataa, exp<=127+31-FRAC_BITS; go to NORM.
- NORM, mant[31]==0: mant<=mant<<1, exp<=exp-1; stay in NORM.
- NORM, mant[31]==1: go to ROUND.
- ROUND:
  - Keep = mant[30:8]; lsb = mant[8]; guard = mant[7]; sticky = |mant[6:0].
  - Round up when guard & (sticky | lsb).
  - Rounding carry out of the 23-bit mantissa: mantissa=0, exp+1.
  - result<={1'b0, exp[7:0], mantissa}; done<=1; go to IDLE.
- Nonzero latency: start edge to done = lz+2 enabled cycles, where lz is the leading-zero count of dataa (0..31). Worst case is 33 cycles.
- start while not IDLE is ignored; the in-flight conversion is unaffected.
- done is high for exactly one enabled cycle after each accepted start.
- Sign bit is always 0. No denormals, infinities or NaNs are possible for the legal FRAC_BITS range (exponent stays within 96..159).

Optional Feature:
- Macro: FIXED_TO_FLOAT_FAST_NORM_EN.
- Defined:
  - A combinational leading-zero count and barrel shift perform the whole normalisation on the start edge.
  - The state goes directly to ROUND, with exp already adjusted by -lz.
  - Nonzero latency is a fixed 2 cycles; zero latency is unchanged at 1.
- Undefined: iterative NORM as described above.
- result values are bit-identical in both builds.

Decomposition:
- cordic_pkg holds:
  - FLOAT_BIAS=127, MANT_W=23, EXP_W=8, FIX_W=32.
  - The state enum (IDLE/NORM/ROUND).
  - A localparam function computing the initial exponent from FRAC_BITS.
- Sub-module leading_zero_count: 32-bit input, 6-bit count output, combinational. Instantiated only under FIXED_TO_FLOAT_FAST_NORM_EN.

Test Plan:
- Exact values, FRAC_BITS=31: 32'h80000000 -> 32'h3F800000 with done at cycle 2. 32'h40000000 -> 32'h3F000000 at cycle 3. 32'h00000001 -> 32'h30000000 at cycle 33 (fast build: cycle 2).
- Zero: dataa=0 -> result 32'h00000000 with done 1 cycle after start; no NORM entry.
- Rounding:
  - 32'h80000040 -> 32'h3F800000 (guard 0).
  - 32'h80000080 -> 32'h3F800000 (tie to even).
  - 32'h80000180 -> 32'h3F800002 (tie, odd lsb, rounds up).
  - 32'hFFFFFFFF -> 32'h40000000 (mantissa carry bumps the exponent).
- Handshake:
  - A second start during NORM is ignored; exactly one done is produced, with the first operand's result.
  - clk_en held low for 5 cycles mid-conversion extends latency by exactly 5.
- Reset: assert reset during NORM of 32'h00000001 -> done=0 and result=0 immediately (asynchronous); a subsequent start converts normally.
- Round trip: drive the cosine unit with theta = 1.0, -1.0, 0.0, 0.5 and chain its output into this block. Results must match a float32 reference cos within 2 ulp: 0x3F0A5140, 0x3F0A5140, 0x3F800000, 0x3F60A940.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and exponent helper for the fixed_to_float
// converter. FIXED_TO_FLOAT_FAST_NORM_EN selects single-cycle normalisation.
package cordic_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int MANT_W     = 23;
    localparam int EXP_W      = 8;
    localparam int FIX_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2
    } state_e;

    // Biased exponent of dataa with its MSB taken as the leading one at bit 31.
    function automatic logic [EXP_W-1:0] init_exp(input int frac_bits);
        return EXP_W'(FLOAT_BIAS + FIX_W - 1 - frac_bits);
    endfunction

endpackage

// File: rtl/fixed_to_float_if.sv
// Custom-instruction handshake bundle between the Nios II core and fixed_to_float.
interface fixed_to_float_if;
    import cordic_pkg::*;

    logic             clk_en;
    logic             start;
    logic [FIX_W-1:0] dataa;
    logic             done;
    logic [FIX_W-1:0] result;

    modport master (output clk_en, start, dataa, input done, result);
    modport slave  (input clk_en, start, dataa, output done, result);
endinterface

// File: rtl/leading_zero_count.sv
// Combinational leading-zero count of a 32-bit word; all-zero input gives 32.
module leading_zero_count
    import cordic_pkg::*;
(
    input  logic [FIX_W-1:0] a,
    output logic [5:0]       count
);

    always_comb begin
        count = 6'd32;
        // Ascending scan so the highest set bit is the last one to write count.
        for (int i = 0; i < FIX_W; i++) begin
            if (a[i]) count = 6'(FIX_W - 1 - i);
        end
    end

endmodule

// File: rtl/fixed_to_float.sv
// Unsigned fixed-point to float32 converter: normalise, then round to nearest even.
// Define FIXED_TO_FLOAT_FAST_NORM_EN for a one-edge barrel-shift normaliser.
module fixed_to_float
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = 31
) (
    input  logic             clk,
    input  logic             reset,
    fixed_to_float_if.slave  bus
);

    localparam logic [EXP_W-1:0] INIT_EXP = init_exp(FRAC_BITS);

    state_e           state, state_n;
    logic [FIX_W-1:0] mant, mant_n;
    logic [EXP_W-1:0] exp, exp_n;
    logic             done_r, done_n;
    logic [FIX_W-1:0] result_r, result_n;

    logic             round_up;
    logic [MANT_W:0]  rnd_sum;

    // mant[31] is the hidden one; mant[8] is the kept lsb, mant[7] the guard.
    assign round_up = mant[7] & ((|mant[6:0]) | mant[8]);
    assign rnd_sum  = {1'b0, mant[30:8]} + (MANT_W+1)'(round_up);

`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
    logic [5:0] lz;

    leading_zero_count u_lzc (
        .a     (bus.dataa),
        .count (lz)
    );
`endif

    always_comb begin
        state_n  = state;
        mant_n   = mant;
        exp_n    = exp;
        done_n   = 1'b0;
        result_n = result_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dataa == '0) begin
                        result_n = '0;
                        done_n   = 1'b1;
                    end else begin
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
                        mant_n  = bus.dataa << lz;
                        exp_n   = INIT_EXP - EXP_W'(lz);
                        state_n = ROUND;
`else
                        mant_n  = bus.dataa;
                        exp_n   = INIT_EXP;
                        state_n = bus.dataa[FIX_W-1] ? ROUND : NORM;
`endif
                    end
                end
            end
            NORM: begin
                // Leave on the same edge as the final shift so latency is lz+2.
                if (mant[FIX_W-1]) begin
                    state_n = ROUND;
                end else begin
                    mant_n = mant << 1;
                    exp_n  = exp - EXP_W'(1);
                    if (mant[FIX_W-2]) state_n = ROUND;
                end
            end
            ROUND: begin
                if (rnd_sum[MANT_W])
                    result_n = {1'b0, exp + EXP_W'(1), {MANT_W{1'b0}}};
                else
                    result_n = {1'b0, exp, rnd_sum[MANT_W-1:0]};
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mant     <= '0;
            exp      <= '0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (bus.clk_en) begin
            state    <= state_n;
            mant     <= mant_n;
            exp      <= exp_n;
            done_r   <= done_n;
            result_r <= result_n;
        end
    end

    assign bus.done   = done_r;
    assign bus.result = result_r;

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed plus randomised checks of fixed_to_float against an arithmetic
// float32 reference (nearest-even rounding computed from integer remainders).
module tb_fixed_to_float;
    localparam int FRAC = 31;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    fixed_to_float_if bus ();

    fixed_to_float #(.FRAC_BITS(FRAC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_float(input logic [31:0] d);
        int     p;
        int     e;
        longint q;
        longint rem;
        longint half;
        if (d == 32'h0) return 32'h0;
        p = 31;
        while (!d[p]) p--;
        e = 127 + p - FRAC;
        if (p <= 23) begin
            q = longint'(d) << (23 - p);
        end else begin
            q    = longint'(d) >> (p - 23);
            rem  = longint'(d) - (q << (p - 23));
            half = longint'(1) << (p - 24);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        return {1'b0, 8'(e), q[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] d);
        int p;
        if (d == 32'h0) return 1;
`ifdef FIXED_TO_FLOAT_FAST_NORM_EN
        return 2;
`else
        p = 31;
        while (!d[p]) p--;
        return (31 - p) + 2;
`endif
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one conversion; optionally stall clk_en and/or fire a stray start.
    task automatic run(input logic [31:0] d, input int stall_at, input int stall_len,
                       input bit extra_start, output logic [31:0] res,
                       output int lat, output int extra_done);
        bus.start = 1'b1;
        bus.dataa = d;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        lat        = 1;
        extra_done = 0;
        while (!bus.done && lat < 80) begin
            if (lat == stall_at) bus.clk_en = 1'b0;
            if (lat == stall_at + stall_len) bus.clk_en = 1'b1;
            if (extra_start && lat == 2) begin
                bus.start = 1'b1;
                bus.dataa = 32'h80000000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start  = 1'b0;
        bus.clk_en = 1'b1;
        res = bus.result;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done) extra_done++;
        end
    endtask

    task automatic conv_check(input string tag, input logic [31:0] d, input logic [31:0] exp_res,
                              input int exp_lat);
        logic [31:0] res;
        int          lat;
        int          xd;
        run(d, -100, 0, 1'b0, res, lat, xd);
        check32({tag, "_result"}, res, exp_res);
        check_int({tag, "_latency"}, lat, exp_lat);
        check_int({tag, "_single_done"}, xd, 0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] d;
        int          lat;
        int          xd;
        int          diff;
        real         theta [4];
        logic [31:0] cos_ref [4];
        longint      fx;

        checks = 0;
        fails  = 0;
        reset      = 1'b1;
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        bus.dataa  = 32'h0;
        #12;
        check32("reset_done", {31'h0, bus.done}, 32'h0);
        check32("reset_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        conv_check("one",      32'h80000000, 32'h3F800000, ref_lat(32'h80000000));
        conv_check("half",     32'h40000000, 32'h3F000000, ref_lat(32'h40000000));
        conv_check("min",      32'h00000001, 32'h30000000, ref_lat(32'h00000001));
        conv_check("zero",     32'h00000000, 32'h00000000, 1);
        conv_check("guard0",   32'h80000040, 32'h3F800000, 2);
        conv_check("tie_even", 32'h80000080, 32'h3F800000, 2);
        conv_check("tie_odd",  32'h80000180, 32'h3F800002, 2);
        conv_check("carry",    32'hFFFFFFFF, 32'h40000000, 2);
        conv_check("zero_after", 32'h00000000, 32'h00000000, 1);

        // Stray start during normalisation must be ignored.
        run(32'h00000100, -100, 0, 1'b1, res, lat, xd);
        check32("busy_start_result", res, ref_float(32'h00000100));
        check_int("busy_start_latency", lat, ref_lat(32'h00000100));
        check_int("busy_start_single_done", xd, 0);

        // Five disabled edges stretch latency by exactly five.
        run(32'h00010000, 1, 5, 1'b0, res, lat, xd);
        check32("stall_result", res, ref_float(32'h00010000));
        check_int("stall_latency", lat, ref_lat(32'h00010000) + 5);

        // Asynchronous reset in the middle of a long conversion.
        bus.start = 1'b1;
        bus.dataa = 32'h00000001;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check32("async_reset_done", {31'h0, bus.done}, 32'h0);
        check32("async_reset_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) lat++;
        end
        check_int("async_reset_no_done", lat, 0);
        conv_check("after_reset", 32'h00000001, 32'h30000000, ref_lat(32'h00000001));

        for (int i = 0; i < 40; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if (i % 9 == 0) d = 32'h0;
            conv_check($sformatf("rand%0d_%08h", i, d), d, ref_float(d), ref_lat(d));
        end

        // Cosine-unit outputs fed back through, compared within 2 ulp.
        theta[0] = 1.0;  cos_ref[0] = 32'h3F0A5140;
        theta[1] = -1.0; cos_ref[1] = 32'h3F0A5140;
        theta[2] = 0.0;  cos_ref[2] = 32'h3F800000;
        theta[3] = 0.5;  cos_ref[3] = 32'h3F60A940;
        for (int i = 0; i < 4; i++) begin
            fx = longint'($cos(theta[i]) * 2147483648.0);
            run(32'(fx), -100, 0, 1'b0, res, lat, xd);
            diff = int'(res) - int'(cos_ref[i]);
            checks++;
            assert (diff <= 2 && diff >= -2) else begin
                fails++;
                $error("FAIL cos_roundtrip%0d observed=%08h expected=%08h", i, res, cos_ref[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
